// File: rtl/pipe_add_pkg.sv
// Shared constants and configuration check for the pipelined ripple adder.
// Contents:
//   DefWidth / DefChunk  default operand width and per-stage chunk width
//   cfg_ok()             returns 1 when a width/chunk pair is legal
package pipe_add_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefChunk = 4;

  // Legal when the chunk is non-empty and tiles the operand exactly.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_ripple_add_if.sv
// Handshake bundle for pipe_ripple_add.
// Signals:
//   in_valid/in_ready    operation handshake (producer -> adder)
//   a, b, cin, sub       operands and mode
//   out_valid/out_ready  result handshake (adder -> consumer)
//   sum, cout, ovf       result word, carry out of MSB, signed overflow
// Modports:
//   master  producer/consumer side (drives operands, accepts results)
//   slave   adder side
interface pipe_ripple_add_if
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/ripple_chunk.sv
// CHUNK-bit combinational ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i   chunk operands
//   cin_i      carry into bit 0
//   sum_o      chunk sum bits
//   cout_o     carry out of the chunk MSB
//   c_msb_o    carry into the chunk MSB (used for signed overflow)
module ripple_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
  end

  assign cout_o  = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/pipe_ripple_add.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple chunk per stage, carry
// registered between stages, valid/ready handshake with full-pipeline stall.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pipe_ripple_add_if.slave (operand and result handshakes)
// Level 0 holds the prepared operands captured at accept; level k+1 holds the
// result of chunk k. Word w_q[k] carries resolved sum bits below chunk k and
// untouched A bits from chunk k upward, so the skew costs no extra registers.
module pipe_ripple_add
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input logic             clk,
  input logic             rst,
  pipe_ripple_add_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $fatal(1, "pipe_ripple_add: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic                  advance;
  logic [STAGES:0]       valid_q, valid_d;
  logic [STAGES:0]       c_q, c_d;
  logic [WIDTH-1:0]      w_q [STAGES+1];
  logic [WIDTH-1:0]      w_d [STAGES+1];
  logic                  ovf_q, ovf_d;

  logic [CHUNK-1:0]      chunk_sum [STAGES];
  logic [STAGES-1:0]     chunk_cout;
  logic [STAGES-1:0]     chunk_cmsb;

  // Whole pipeline moves together; bubbles are held too.
  assign advance      = !valid_q[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Bw = WIDTH - k * CHUNK;

    // Remaining B_eff chunks, current chunk at the bottom; shrinks per level.
    logic [Bw-1:0] b_q, b_d;

    if (k == 0) begin : g_first
      // Gated by in_valid so bubbles carry zeros and never X.
      assign b_d = bus.in_valid ? (bus.sub ? ~bus.b : bus.b) : '0;
    end else begin : g_next
      assign b_d = g_stage[k-1].b_q[Bw+CHUNK-1:CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_q <= '0;
      end else if (advance) begin
        b_q <= b_d;
      end
    end

    ripple_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i     (w_q[k][k*CHUNK +: CHUNK]),
      .b_i     (b_q[CHUNK-1:0]),
      .cin_i   (c_q[k]),
      .sum_o   (chunk_sum[k]),
      .cout_o  (chunk_cout[k]),
      .c_msb_o (chunk_cmsb[k])
    );
  end

  always_comb begin
    valid_d[0] = bus.in_valid;
    w_d[0]     = bus.in_valid ? bus.a : '0;
    c_d[0]     = bus.in_valid & (bus.sub | bus.cin);
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k+1]                  = valid_q[k];
      w_d[k+1]                      = w_q[k];
      w_d[k+1][k*CHUNK +: CHUNK]    = chunk_sum[k];
      c_d[k+1]                      = chunk_cout[k];
    end
    ovf_d = chunk_cout[STAGES-1] ^ chunk_cmsb[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k <= STAGES; k++) begin
        w_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k <= STAGES; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES];
  assign bus.sum       = w_q[STAGES];
  assign bus.cout      = valid_q[STAGES] & c_q[STAGES];
  assign bus.ovf       = valid_q[STAGES] & ovf_q;

endmodule

// File: tb/tb_pipe_ripple_add.sv
// Self-checking bench for pipe_ripple_add at default parameters (16/4).
module tb_pipe_ripple_add;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_ripple_add_if #(.WIDTH(16)) bus ();

  pipe_ripple_add #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] exp_q [$];

  // Reference: {ovf, cout, sum} from plain integer arithmetic and sign rules.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] beff;
    logic [16:0] r;
    logic        v;
    beff = sub ? ~b : b;
    r    = {1'b0, a} + {1'b0, beff} + {16'd0, (sub ? 1'b1 : cin)};
    v    = (a[15] == beff[15]) && (r[15] != a[15]);
    return {v, r[16], r[15:0]};
  endfunction

  // Presents one op, waits for its result; lat is edges after accept (99 = timeout).
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int lat, output logic [15:0] s,
                         output logic co, output logic ov);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 99; s = 'x; co = 1'bx; ov = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = i; s = bus.sum; co = bus.cout; ov = bus.ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b want all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    logic [15:0] va [7] = '{16'h0009, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h00FF, 16'h0003};
    logic [15:0] vb [7] = '{16'h0007, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'h0003};
    logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] es [7] = '{16'h0010, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0100, 16'h0000};
    logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int          lat;
    logic [15:0] s;
    logic        co, ov;
    for (int i = 0; i < 7; i++) begin
      run_one(va[i], vb[i], vc[i], vs[i], lat, s, co, ov);
      checks++;
      if (lat !== 4) begin
        errors++; $display("FAIL single%0d_latency: got %0d want 4", i, lat);
      end
      checks++;
      if ({s, co, ov} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL single%0d_result: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                 i, s, co, ov, es[i], ec[i], eo[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single%0d_idle_flags: got v=%b c=%b o=%b want 0 0 0",
                 i, bus.out_valid, bus.cout, bus.ovf);
      end
    end
  endtask

  // Streams n ops; out_ready drops for stall_len cycles starting at cycle stall_at.
  task automatic test_stream(input int n, input int stall_at, input int stall_len,
                             input string name);
    int          idx = 0, got = 0, first = -1, last = -1, stalls = 0;
    logic [17:0] held, obs, e;
    bit          have_held = 0;
    logic [15:0] a, b;
    logic        cin, sub;
    exp_q.delete();
    for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      obs = {bus.ovf, bus.cout, bus.sum};
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_extra: got result %h want none", name, obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              errors++; $display("FAIL %s_result%0d: got %h want %h", name, got, obs, e);
            end
          end
          got++;
          if (first < 0) first = cyc;
          last = cyc;
          have_held = 0;
        end else begin
          stalls++;
          checks++;
          if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL %s_stall_in_ready: got %b want 0", name, bus.in_ready);
          end
          if (have_held) begin
            checks++;
            if (obs !== held) begin
              errors++; $display("FAIL %s_stall_hold: got %h want %h", name, obs, held);
            end
          end
          held = obs;
          have_held = 1;
        end
      end
      if (idx < n) begin
        a   = 16'(idx * 40503 + 12345);
        b   = 16'(idx * 7919) ^ 16'hA5A5;
        cin = idx[0];
        sub = idx[1];
        if (idx == 0) begin a = 16'hFFFF; b = 16'h0000; cin = 1'b1; sub = 1'b0; end
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
          idx++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    checks++;
    if (got !== n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d results (%0d pending) want %0d", name, got,
               exp_q.size(), n);
    end
    if (stall_len == 0) begin
      checks++;
      if (last - first !== n - 1) begin
        errors++; $display("FAIL %s_rate: got span %0d want %0d", name, last - first, n - 1);
      end
    end else begin
      checks++;
      if (stalls !== stall_len) begin
        errors++; $display("FAIL %s_stall_cycles: got %0d want %0d", name, stalls, stall_len);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    int          lat;
    logic [15:0] s;
    logic        co, ov;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.a = 16'(i + 1); bus.b = 16'h0100; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0101 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flight_precond: got v=%b s=%h r=%b want v=1 s=0101 r=0",
               bus.out_valid, bus.sum, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL flight_async_reset: got v=%b s=%h c=%b want 0 0000 0",
               bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flight_in_ready: got %b want 1", bus.in_ready);
    end
    run_one(16'h1234, 16'h1111, 1'b0, 1'b0, lat, s, co, ov);
    checks++;
    if (lat !== 4 || s !== 16'h2345 || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL flight_next_op: got lat=%0d s=%h c=%b o=%b want lat=4 s=2345 c=0 o=0",
               lat, s, co, ov);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_stream(20, 1000, 0, "back_to_back");
    test_stream(12, 8, 3, "backpressure");
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
